buf_rx_fifo: RTL and testbench

Clocked four-phase receiver sitting directly downstream of BUF, replacing the behavioural Receiver with a synthesizable stage. It synchronises `BtoR_REQ`, captures `DO` into a small FIFO, and answers with `RtoB_ACK`. It withholds the acknowledge while the FIFO is full, which back-pressures BUF and, through BUF, the Sender. Captured words are presented to the consumer on a valid/ready port.

---
 rtl/buf_rx_fifo.sv | 121 ++++++++++++
 tb/tb_buf_rx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_rx_fifo.sv
// Clocked four-phase receiver behind BUF: synchronises BtoR_REQ, pushes DO into a small FIFO, and acknowledges.
// Optional push-sequence checker is enabled by defining BUF_RX_SEQ_CHECK_EN.
module buf_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BtoR_REQ,
    input  logic [31:0]   DO,
    output logic          RtoB_ACK,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [LW-1:0] level,
    output logic          seq_err,
    output logic [15:0]   err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACKED} state_t;

    state_t        state_reg, state_next;
    logic          req_meta_reg, req_s_reg;
    logic [31:0]   mem [DEPTH];
    logic [LW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_int;
    logic          full, empty, push, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_meta_reg <= 1'b0;
            req_s_reg    <= 1'b0;
        end else begin
            req_meta_reg <= BtoR_REQ;
            req_s_reg    <= req_meta_reg;
        end
    end

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign level_int = wr_ptr_reg - rd_ptr_reg;
    assign full      = (level_int == LW'(DEPTH));
    assign empty     = (level_int == '0);
    assign pop       = !empty && out_ready;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_s_reg && !full) begin
                    push       = 1'b1;
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (!req_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= DO;
        end
    end

    assign RtoB_ACK  = (state_reg == ACKED);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_reg[AW-1:0]];
    assign level     = level_int;

`ifdef BUF_RX_SEQ_CHECK_EN
    logic [31:0] expect_reg;
    logic        seq_err_reg;
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            expect_reg  <= '0;
            seq_err_reg <= 1'b0;
            err_cnt_reg <= '0;
        end else if (push) begin
            expect_reg <= DO + 32'd1;
            if (DO != expect_reg) begin
                seq_err_reg <= 1'b1;
                if (err_cnt_reg != 16'hFFFF) begin
                    err_cnt_reg <= err_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign seq_err = seq_err_reg;
    assign err_cnt = err_cnt_reg;
`else
    assign seq_err = 1'b0;
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_buf_rx_fifo.sv
// Directed bench for buf_rx_fifo: handshake latency, backpressure, streaming wrap, push/pop overlap, reset, sequence check.
module tb_buf_rx_fifo;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [31:0]   do_data = '0;
    logic          ack;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [LW-1:0] level;
    logic          seq_err;
    logic [15:0]   err_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic        mon_en = 1'b0;
    logic [31:0] mon_expect = '0;
    int          mon_count = 0;
    int          max_level = 0;

    buf_rx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .BtoR_REQ  (req),
        .DO        (do_data),
        .RtoB_ACK  (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .seq_err   (seq_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, got, got, want, want);
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        out_ready = 1'b0;
        edges(2);
        rst = 1'b0;
    endtask

    // Full four-phase transaction with bounded waits; starts and ends at a falling edge.
    task automatic do_xfer(input logic [31:0] data);
        int n;
        do_data = data;
        req = 1'b1;
        n = 0;
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_vec("xfer_ack_rise", {31'd0, ack}, 32'd1);
        req = 1'b0;
        n = 0;
        while (ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_vec("xfer_ack_fall", {31'd0, ack}, 32'd0);
    endtask

    // Pop observer used while streaming: a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(level) > max_level) max_level = int'(level);
            if (out_valid && out_ready) begin
                check_vec("stream_data", out_data, mon_expect);
                mon_expect = mon_expect + 32'd1;
                mon_count++;
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        check_vec("rst_ack", {31'd0, ack}, 32'd0);
        check_vec("rst_valid", {31'd0, out_valid}, 32'd0);
        check_vec("rst_level", 32'(level), 32'd0);
        check_vec("rst_seq_err", {31'd0, seq_err}, 32'd0);
        check_vec("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Single transfer and exact acknowledge latency
        do_data = 32'h0000_002A;
        req = 1'b1;
        edges(2);
        check_vec("single_ack_2edges", {31'd0, ack}, 32'd0);
        check_vec("single_level_2edges", 32'(level), 32'd0);
        edges(1);
        check_vec("single_ack_3edges", {31'd0, ack}, 32'd1);
        check_vec("single_level", 32'(level), 32'd1);
        check_vec("single_valid", {31'd0, out_valid}, 32'd1);
        check_vec("single_data", out_data, 32'd42);
        req = 1'b0;
        edges(2);
        check_vec("single_ack_hold", {31'd0, ack}, 32'd1);
        edges(1);
        check_vec("single_ack_fall", {31'd0, ack}, 32'd0);
        check_vec("single_level_kept", 32'(level), 32'd1);
        out_ready = 1'b1;
        edges(1);
        out_ready = 1'b0;
        check_vec("single_popped", 32'(level), 32'd0);

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) do_xfer(32'(i));
        check_vec("bp_level_full", 32'(level), 32'd4);
        do_data = 32'd4;
        req = 1'b1;
        edges(12);
        check_vec("bp_fifth_held", {31'd0, ack}, 32'd0);
        check_vec("bp_level_still", 32'(level), 32'd4);
        check_vec("bp_head", out_data, 32'd0);
        out_ready = 1'b1;
        edges(1);
        out_ready = 1'b0;
        check_vec("bp_no_push_on_pop", {31'd0, ack}, 32'd0);
        check_vec("bp_level_after_pop", 32'(level), 32'd3);
        edges(1);
        check_vec("bp_fifth_ack", {31'd0, ack}, 32'd1);
        check_vec("bp_level_refill", 32'(level), 32'd4);
        check_vec("bp_head_next", out_data, 32'd1);
        req = 1'b0;
        edges(3);
        check_vec("bp_fifth_ack_fall", {31'd0, ack}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check_vec("bp_drain", out_data, 32'(i));
            out_ready = 1'b1;
            edges(1);
            out_ready = 1'b0;
        end
        check_vec("bp_drained", 32'(level), 32'd0);

        // Streaming with pointer wrap
        do_reset();
        out_ready = 1'b1;
        mon_expect = '0;
        mon_count = 0;
        max_level = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) do_xfer(32'(i));
        edges(3);
        mon_en = 1'b0;
        out_ready = 1'b0;
        check_vec("stream_count", 32'(mon_count), 32'd100);
        check_vec("stream_max_level", 32'(max_level), 32'd1);
        check_vec("stream_empty", 32'(level), 32'd0);

        // Simultaneous push and pop
        do_reset();
        do_xfer(32'd10);
        do_xfer(32'd11);
        check_vec("pp_level_before", 32'(level), 32'd2);
        do_data = 32'd12;
        req = 1'b1;
        edges(2);
        out_ready = 1'b1;
        edges(1);
        out_ready = 1'b0;
        check_vec("pp_ack", {31'd0, ack}, 32'd1);
        check_vec("pp_level", 32'(level), 32'd2);
        check_vec("pp_head", out_data, 32'd11);
        req = 1'b0;
        edges(3);
        check_vec("pp_ack_fall", {31'd0, ack}, 32'd0);

        // Reset mid-transaction
        do_reset();
        do_data = 32'd77;
        req = 1'b1;
        edges(3);
        check_vec("mid_ack_before", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        edges(1);
        check_vec("mid_ack_reset", {31'd0, ack}, 32'd0);
        check_vec("mid_level_reset", 32'(level), 32'd0);
        check_vec("mid_valid_reset", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        edges(2);
        check_vec("mid_ack_2edges", {31'd0, ack}, 32'd0);
        edges(1);
        check_vec("mid_recapture_ack", {31'd0, ack}, 32'd1);
        check_vec("mid_recapture_level", 32'(level), 32'd1);
        check_vec("mid_recapture_data", out_data, 32'd77);
        req = 1'b0;
        edges(3);

        // Sequence checker
        do_reset();
        out_ready = 1'b1;
        do_xfer(32'd0);
        do_xfer(32'd1);
        do_xfer(32'd2);
        check_vec("seq_clean", {31'd0, seq_err}, 32'd0);
        do_xfer(32'd5);
`ifdef BUF_RX_SEQ_CHECK_EN
        check_vec("seq_err_after5", {31'd0, seq_err}, 32'd1);
        check_vec("seq_cnt_after5", 32'(err_cnt), 32'd1);
`else
        check_vec("seq_err_after5", {31'd0, seq_err}, 32'd0);
        check_vec("seq_cnt_after5", 32'(err_cnt), 32'd0);
`endif
        do_xfer(32'd6);
        do_xfer(32'd9);
`ifdef BUF_RX_SEQ_CHECK_EN
        check_vec("seq_err_end", {31'd0, seq_err}, 32'd1);
        check_vec("seq_cnt_end", 32'(err_cnt), 32'd2);
`else
        check_vec("seq_err_end", {31'd0, seq_err}, 32'd0);
        check_vec("seq_cnt_end", 32'(err_cnt), 32'd0);
`endif
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
